// File: rtl/cmd_pkg.sv
// Shared command-path definitions: frame width/type, default sync word, arbiter states.
package cmd_pkg;

   localparam int unsigned FRAME_W = 16;

   typedef logic [FRAME_W-1:0] frame_t;

   localparam frame_t DEFAULT_SYNC_WORD = 16'h817E;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/cmd_rr_select.sv
// Combinational round-robin picker: first set request at or after i_ptr wins,
// o_next_ptr points one past the winner with wrap-around.
module cmd_rr_select #(
   parameter int unsigned N = 2,
   parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_ptr,
   output logic [N-1:0] o_grant,
   output logic         o_valid,
   output logic [W-1:0] o_next_ptr
);

   always_comb begin
      int unsigned w_idx;
      logic [W-1:0] w_sel;
      o_grant    = '0;
      o_valid    = 1'b0;
      o_next_ptr = i_ptr;
      w_idx      = 0;
      w_sel      = '0;
      for (int unsigned k = 0; k < N; k++) begin
         w_idx = 32'(i_ptr) + k;
         if (w_idx >= N) w_idx = w_idx - N;
         w_sel = W'(w_idx);
         if (!o_valid && i_req[w_sel]) begin
            o_valid        = 1'b1;
            o_grant[w_sel] = 1'b1;
            o_next_ptr     = (w_idx == N - 1) ? '0 : W'(w_idx + 1);
         end
      end
   end

endmodule

// File: rtl/cmd_arbiter.sv
// Command-line arbiter/serializer: requester 0 fixed priority, 1..NREQ-1 round-robin,
// packets locked until LAST. Optional forced sync insertion via CMD_ARB_FORCE_SYNC_EN.
module cmd_arbiter
   import cmd_pkg::*;
#(
   parameter int unsigned NREQ          = 3,
   parameter frame_t      SYNC_WORD     = DEFAULT_SYNC_WORD,
   parameter int unsigned SYNC_INTERVAL = 32
) (
   input  logic                    CMD_CLK,
   input  logic                    CMD_RST,
   input  logic                    EN,
   input  logic [NREQ-1:0]         REQ_VALID,
   input  logic [FRAME_W*NREQ-1:0] REQ_DATA,
   input  logic [NREQ-1:0]         REQ_LAST,
   output logic [NREQ-1:0]         REQ_READY,
   output logic [NREQ-1:0]         GRANT,
   output logic                    CMD_SERIAL_OUT,
   output logic                    CMD_OUTPUT_EN,
   output logic                    BUSY
);

   localparam int unsigned NRR = NREQ - 1;
   localparam int unsigned PW  = $clog2(NREQ);
   localparam int unsigned RW  = (NRR > 1) ? $clog2(NRR) : 1;

   if (NREQ < 2 || NREQ > 8 || SYNC_INTERVAL == 0) begin : g_param_check
      $error("cmd_arbiter: NREQ must be 2..8 and SYNC_INTERVAL nonzero");
   end

   state_t          r_state, w_state_nxt;
   logic [3:0]      r_bit_cnt;
   frame_t          r_shift;
   logic            r_serial, r_oen, r_busy;
   logic [NREQ-1:0] r_ready, r_grant;
   logic            r_lock;
   logic [PW-1:0]   r_owner, r_rr_ptr;

   logic            w_load, w_take, w_rr_take, w_last, w_force;
   logic [PW-1:0]   w_win, w_rr_win;
   frame_t          w_frame;
   logic [RW-1:0]   w_rr_ptr, w_rr_next;
   logic [NRR-1:0]  w_rr_grant;
   logic            w_rr_valid;

   // The round-robin pointer is kept as an absolute requester index (1..NREQ-1).
   assign w_rr_ptr = RW'(r_rr_ptr - PW'(1));

   cmd_rr_select #(
      .N (NRR),
      .W (RW)
   ) u_rr (
      .i_req      (REQ_VALID[NREQ-1:1]),
      .i_ptr      (w_rr_ptr),
      .o_grant    (w_rr_grant),
      .o_valid    (w_rr_valid),
      .o_next_ptr (w_rr_next)
   );

   always_comb begin
      w_rr_win = '0;
      for (int unsigned i = 0; i < NRR; i++)
         if (w_rr_grant[i]) w_rr_win = PW'(i + 1);
   end

`ifdef CMD_ARB_FORCE_SYNC_EN
   logic [31:0] r_data_cnt;

   assign w_force = (r_data_cnt >= SYNC_INTERVAL);

   always_ff @(posedge CMD_CLK or posedge CMD_RST) begin
      if (CMD_RST)     r_data_cnt <= '0;
      else if (w_load) r_data_cnt <= w_take ? r_data_cnt + 32'd1 : '0;
   end
`else
   assign w_force = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         IDLE: if (EN) begin
            w_load      = 1'b1;
            w_state_nxt = RUN;
         end
         RUN: if (r_bit_cnt == 4'd15) begin
            if (EN) w_load = 1'b1;
            else    w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge CMD_CLK or posedge CMD_RST) begin
      if (CMD_RST) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_take    = 1'b0;
      w_rr_take = 1'b0;
      w_win     = '0;
      if (!w_force) begin
         if (r_lock) begin
            if (REQ_VALID[r_owner]) begin
               w_take = 1'b1;
               w_win  = r_owner;
            end
         end else if (REQ_VALID[0]) begin
            w_take = 1'b1;
         end else if (w_rr_valid) begin
            w_take    = 1'b1;
            w_rr_take = 1'b1;
            w_win     = w_rr_win;
         end
      end
      w_frame = w_take ? REQ_DATA[32'(w_win)*FRAME_W +: FRAME_W] : SYNC_WORD;
      w_last  = REQ_LAST[w_win];
   end

   always_ff @(posedge CMD_CLK or posedge CMD_RST) begin
      if (CMD_RST) begin
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_serial  <= 1'b0;
         r_oen     <= 1'b0;
         r_busy    <= 1'b0;
         r_ready   <= '0;
         r_grant   <= '0;
         r_lock    <= 1'b0;
         r_owner   <= '0;
         r_rr_ptr  <= PW'(1);
      end else begin
         r_ready <= '0;
         r_busy  <= (w_state_nxt == RUN);
         if (w_load) begin
            r_bit_cnt <= '0;
            r_serial  <= w_frame[FRAME_W-1];
            r_shift   <= {w_frame[FRAME_W-2:0], 1'b0};
            r_oen     <= 1'b1;
            if (w_take) begin
               r_ready <= NREQ'(1) << w_win;
               if (w_last) begin
                  r_lock  <= 1'b0;
                  r_grant <= '0;
               end else begin
                  r_lock  <= 1'b1;
                  r_owner <= w_win;
                  r_grant <= NREQ'(1) << w_win;
               end
               if (w_rr_take) r_rr_ptr <= PW'(w_rr_next) + PW'(1);
            end
         end else if (r_state == RUN) begin
            if (r_bit_cnt == 4'd15) begin
               r_bit_cnt <= '0;
               r_serial  <= 1'b0;
               r_oen     <= 1'b0;
            end else begin
               r_bit_cnt <= r_bit_cnt + 4'd1;
               r_serial  <= r_shift[FRAME_W-1];
               r_shift   <= {r_shift[FRAME_W-2:0], 1'b0};
            end
         end
      end
   end

   assign REQ_READY      = r_ready;
   assign GRANT          = r_grant;
   assign CMD_SERIAL_OUT = r_serial;
   assign CMD_OUTPUT_EN  = r_oen;
   assign BUSY           = r_busy;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed self-checking bench for cmd_arbiter (NREQ=3, SYNC_INTERVAL=4 override).
module tb_cmd_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        EN;
   logic [2:0]  REQ_VALID;
   logic [47:0] REQ_DATA;
   logic [2:0]  REQ_LAST;
   logic [2:0]  REQ_READY;
   logic [2:0]  GRANT;
   logic        CMD_SERIAL_OUT;
   logic        CMD_OUTPUT_EN;
   logic        BUSY;

   int n_total = 0;
   int n_pass  = 0;

   localparam logic [15:0] SYNC = 16'h817E;

   cmd_arbiter #(
      .NREQ          (3),
      .SYNC_WORD     (16'h817E),
      .SYNC_INTERVAL (4)
   ) dut (
      .CMD_CLK        (clk),
      .CMD_RST        (rst),
      .EN             (EN),
      .REQ_VALID      (REQ_VALID),
      .REQ_DATA       (REQ_DATA),
      .REQ_LAST       (REQ_LAST),
      .REQ_READY      (REQ_READY),
      .GRANT          (GRANT),
      .CMD_SERIAL_OUT (CMD_SERIAL_OUT),
      .CMD_OUTPUT_EN  (CMD_OUTPUT_EN),
      .BUSY           (BUSY)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic set_req(input int i, input logic v, input logic [15:0] d, input logic l);
      REQ_VALID[i]         = v;
      REQ_DATA[16*i +: 16] = d;
      REQ_LAST[i]          = l;
   endtask

   // Collects one 16-bit frame starting at the next falling edge; optionally drops EN after bit drop_at.
   task automatic frame_check(input string tag, input int drop_at, input logic [15:0] ef,
                              input logic [2:0] er, input logic [2:0] eg);
      logic [15:0] f;
      logic [2:0]  rmask, g0;
      int          rcnt;
      logic        oen_all, busy_all;
      f = '0; rmask = '0; g0 = '0; rcnt = 0; oen_all = 1'b1; busy_all = 1'b1;
      for (int b = 0; b < 16; b++) begin
         @(negedge clk);
         f = {f[14:0], CMD_SERIAL_OUT};
         if (b == 0) g0 = GRANT;
         rmask = rmask | REQ_READY;
         if (REQ_READY != 3'b000) rcnt++;
         oen_all  = oen_all & CMD_OUTPUT_EN;
         busy_all = busy_all & BUSY;
         if (b == drop_at) EN = 1'b0;
      end
      check({tag, ".data"}, 32'(f), 32'(ef));
      check({tag, ".ready"}, 32'(rmask), 32'(er));
      check({tag, ".readycnt"}, 32'(rcnt), (er != 3'b000) ? 32'd1 : 32'd0);
      check({tag, ".grant"}, 32'(g0), 32'(eg));
      check({tag, ".oen"}, 32'(oen_all), 32'd1);
      check({tag, ".busy"}, 32'(busy_all), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] ef;
      logic [2:0]  er;
      rst = 1'b0; EN = 1'b0;
      REQ_VALID = '0; REQ_DATA = '0; REQ_LAST = '0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst.serial", 32'(CMD_SERIAL_OUT), 32'd0);
      check("rst.oen",    32'(CMD_OUTPUT_EN),  32'd0);
      check("rst.ready",  32'(REQ_READY),      32'd0);
      check("rst.grant",  32'(GRANT),          32'd0);
      check("rst.busy",   32'(BUSY),           32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle.oen",  32'(CMD_OUTPUT_EN), 32'd0);
      check("idle.busy", 32'(BUSY),          32'd0);

      // Idle line: continuous sync words
      EN = 1'b1;
      for (int i = 0; i < 3; i++) frame_check("sync", -1, SYNC, 3'b000, 3'b000);

      // Two single-frame requesters alternate
      set_req(1, 1'b1, 16'hAAAA, 1'b1);
      set_req(2, 1'b1, 16'h5555, 1'b1);
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) frame_check("rr1", -1, 16'hAAAA, 3'b010, 3'b000);
         else            frame_check("rr2", -1, 16'h5555, 3'b100, 3'b000);
      end

      // Locked packet from req1 is not preempted by req0
      set_req(2, 1'b0, 16'h0000, 1'b0);
      set_req(1, 1'b1, 16'h1111, 1'b0);
      frame_check("pkt.f1", -1, 16'h1111, 3'b010, 3'b010);
      set_req(0, 1'b1, 16'h6969, 1'b1);
      set_req(1, 1'b1, 16'h2222, 1'b0);
      frame_check("pkt.f2", -1, 16'h2222, 3'b010, 3'b010);
      set_req(1, 1'b1, 16'h3333, 1'b1);
      frame_check("pkt.f3", -1, 16'h3333, 3'b010, 3'b000);
      set_req(1, 1'b0, 16'h0000, 1'b0);
      frame_check("pri0", -1, 16'h6969, 3'b001, 3'b000);
      set_req(0, 1'b0, 16'h0000, 1'b0);

      // Locked owner stalls: sync fills, other requesters stay blocked
      set_req(2, 1'b1, 16'hBEEF, 1'b0);
      frame_check("lock.f1", -1, 16'hBEEF, 3'b100, 3'b100);
      set_req(2, 1'b0, 16'hBEEF, 1'b0);
      set_req(1, 1'b1, 16'hCAFE, 1'b1);
      frame_check("lock.gap1", -1, SYNC, 3'b000, 3'b100);
      frame_check("lock.gap2", -1, SYNC, 3'b000, 3'b100);
      set_req(2, 1'b1, 16'hF00D, 1'b1);
      frame_check("lock.f2", -1, 16'hF00D, 3'b100, 3'b000);
      set_req(2, 1'b0, 16'h0000, 1'b0);
      frame_check("lock.after", -1, 16'hCAFE, 3'b010, 3'b000);

      // EN dropped mid-frame: frame completes, then idle
      set_req(1, 1'b1, 16'h1234, 1'b1);
      frame_check("endrop", 7, 16'h1234, 3'b010, 3'b000);
      set_req(1, 1'b0, 16'h0000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("endrop.oen",    32'(CMD_OUTPUT_EN),  32'd0);
         check("endrop.busy",   32'(BUSY),           32'd0);
         check("endrop.serial", 32'(CMD_SERIAL_OUT), 32'd0);
      end

      // Asynchronous reset in the middle of a frame
      set_req(1, 1'b1, 16'h5A5A, 1'b1);
      EN = 1'b1;
      repeat (5) @(negedge clk);
      check("midrst.pre_oen", 32'(CMD_OUTPUT_EN), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("midrst.oen",    32'(CMD_OUTPUT_EN),  32'd0);
      check("midrst.serial", 32'(CMD_SERIAL_OUT), 32'd0);
      check("midrst.busy",   32'(BUSY),           32'd0);
      check("midrst.grant",  32'(GRANT),          32'd0);
      check("midrst.ready",  32'(REQ_READY),      32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Continuous single requester: forced sync cadence only when the feature is built
      set_req(1, 1'b1, 16'h7777, 1'b1);
      for (int i = 0; i < 10; i++) begin
         ef = 16'h7777;
         er = 3'b010;
`ifdef CMD_ARB_FORCE_SYNC_EN
         if (i % 5 == 4) begin
            ef = SYNC;
            er = 3'b000;
         end
`endif
         frame_check("stream", -1, ef, er, 3'b000);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
